exc_controller: RTL
===================

Name: exc_controller

Overview:
- Parametrised exception/interrupt sequencer for the LEGv8 single-cycle core. It sits beside the main and ALU decoders.
- Takes N_IRQ external level-sensitive interrupt lines plus the illegal-opcode flag from the main decoder.
- Selects one event by fixed priority and drives the Exc/EStatus redirect handshake toward the ELR/ESR/PC logic.
- Detects ERET and returns to normal execution. Interrupts are non-nested; a fault inside the handler raises a sticky double fault.

Parameters:
N_IRQ, 4, number of external interrupt channels (legal 1..8)
ESTATUS_W, 4, width of the EStatus cause code (must be >= 4)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
instr  in  11  opcode field instr[31:21] of the current instruction
illegal_op  in  1  main decoder flags an unimplemented opcode this cycle
irq  in  N_IRQ  external interrupt requests, level, held until acknowledged
irq_en  in  N_IRQ  per-channel enable mask (1 = enabled)
exc_ack  in  1  ELR/ESR/PC redirect committed by the datapath
exc  out  1  exception pending; PC mux selects vector while high
estatus  out  ESTATUS_W  cause code of the last taken exception
eret  out  1  ERET executing in handler; PC mux selects ELR
ext_iack  out  N_IRQ  one-hot acknowledge of the taken interrupt channel
in_handler  out  1  core is executing the exception handler
double_fault  out  1  sticky fault raised inside the handler

Behaviour:
- Reset (reset==0 at a rising edge) puts every output at 0 and the state in RUN. Reset overrides all other inputs, including mid-handshake.
- The ERET opcode is 11'b11010110100. Cause codes: 0 = none, 1 = illegal opcode or ERET outside the handler, 8+i = IRQ channel i.
- States: RUN, PEND, HANDLER.
- RUN, event selection:
  - Candidate events are illegal_op, ERET, or any (irq & irq_en) bit.
  - Priority: illegal_op or ERET (cause 1) wins over any IRQ. Among IRQs the lowest index wins.
- RUN, on an event:
  - Next edge: state goes to PEND, estatus latches the cause, exc goes to 1.
  - If the event is IRQ i, ext_iack[i] goes to 1 on the same edge.
  - eret is 0 throughout RUN.
- PEND:
  - exc stays 1 until exc_ack is sampled high.
  - On that edge: state goes to HANDLER, exc goes to 0, in_handler goes to 1.
  - Event inputs are ignored in PEND.
  - The latched cause is kept even if irq drops during PEND.
- HANDLER:
  - All IRQs are masked (no nesting).
  - eret is combinational: 1 while state==HANDLER and instr==ERET.
  - On that edge: state returns to RUN and in_handler goes to 0.
- HANDLER, illegal_op while not ERET: double_fault is set to 1 and stays 1 until reset. The state is unchanged.
- ext_iack handshake:
  - ext_iack[i] stays 1 until irq[i] is sampled low; it clears on the following edge, independent of state.
  - At most one ext_iack bit is high at a time.
  - A new IRQ i is not taken while ext_iack[i] is still 1.
- estatus holds its value until the next taken event. It never returns to 0 except on reset.
- exc_ack outside PEND is ignored.
- Latency: 1 cycle from event to exc. exc lasts 1 or more cycles, depending on exc_ack.

Decomposition:
- Shared package exc_pkg holds:
  - state enum exc_state_t {RUN, PEND, HANDLER}
  - ERET_OPC constant
  - cause constants CAUSE_NONE=0, CAUSE_ILLEGAL=1, CAUSE_IRQ_BASE=8
- One sub-module, irq_prio_enc: parametrised lowest-index-wins priority encoder. Outputs a valid bit and an index of width $clog2(N_IRQ) (minimum 1).
- The FSM, handshake and ERET decode stay in exc_controller.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with irq=4'hF and irq_en=4'hF -> all outputs 0. Release -> exc=1, estatus=8, ext_iack=4'b0001 one cycle later.
2. Priority: illegal_op=1 together with irq=4'b0110, irq_en=4'hF in RUN -> estatus=1, ext_iack=0. After exc_ack, in_handler=1.
3. IRQ path: irq[2]=1, irq_en=4'b0100 -> exc=1, estatus=10, ext_iack=4'b0100. Hold exc_ack=0 for 3 cycles -> exc stays 1. Pulse exc_ack -> exc=0, in_handler=1. Drop irq[2] -> ext_iack=0 next cycle.
4. Return: in HANDLER drive instr=11'b11010110100 -> eret=1 in the same cycle, in_handler=0 next cycle. The same opcode in RUN -> exc=1, estatus=1, eret=0.
5. Masking and nesting: in HANDLER assert irq[0] -> no exc. After ERET with irq[0] still high and irq_en[0]=1 -> exc=1, estatus=8 one cycle later.
6. Double fault: in HANDLER assert illegal_op -> double_fault=1 and stays 1 after ERET. Only reset=0 clears it.

Source files
------------

// File: rtl/exc_pkg.sv
// exc_pkg: shared states, ERET opcode and cause codes for the exception sequencer
package exc_pkg;
  typedef enum logic [1:0] {RUN, PEND, HANDLER} exc_state_t;
  localparam logic [10:0] ERET_OPC = 11'b11010110100;
  localparam int CAUSE_NONE = 0;
  localparam int CAUSE_ILLEGAL = 1;
  localparam int CAUSE_IRQ_BASE = 8;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder; req_i -> valid_o, idx_o
module irq_prio_enc #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[i]) idx_o = i[IW-1:0];
  end
endmodule

// File: rtl/exc_controller.sv
// exc_controller: exception/interrupt sequencer; clk/reset(active-low sync), instr/illegal_op/irq/irq_en/exc_ack in; exc/estatus/eret/ext_iack/in_handler/double_fault out
module exc_controller
  import exc_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int ESTATUS_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          instr,
  input  logic                 illegal_op,
  input  logic [N_IRQ-1:0]     irq,
  input  logic [N_IRQ-1:0]     irq_en,
  input  logic                 exc_ack,
  output logic                 exc,
  output logic [ESTATUS_W-1:0] estatus,
  output logic                 eret,
  output logic [N_IRQ-1:0]     ext_iack,
  output logic                 in_handler,
  output logic                 double_fault
);
  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  exc_state_t state_q, state_d;
  logic [ESTATUS_W-1:0] estatus_q, estatus_d;
  logic [N_IRQ-1:0] iack_q, iack_d;
  logic dfault_q, dfault_d;
  logic irq_v;
  logic [IW-1:0] irq_idx;
  logic is_eret;
  assign is_eret = instr == ERET_OPC;
  // any outstanding acknowledge blocks new IRQs so at most one iack bit is ever high
  irq_prio_enc #(.N(N_IRQ)) u_enc (
    .req_i  (irq & irq_en & {N_IRQ{~|iack_q}}),
    .valid_o(irq_v),
    .idx_o  (irq_idx)
  );
  always_comb begin
    state_d = state_q;
    estatus_d = estatus_q;
    iack_d = iack_q & irq;
    dfault_d = dfault_q;
    case (state_q)
      RUN:
        if (illegal_op || is_eret) begin
          state_d = PEND;
          estatus_d = ESTATUS_W'(CAUSE_ILLEGAL);
        end else if (irq_v) begin
          state_d = PEND;
          estatus_d = ESTATUS_W'(CAUSE_IRQ_BASE) + ESTATUS_W'(irq_idx);
          iack_d = N_IRQ'(1) << irq_idx;
        end
      PEND: state_d = exc_ack ? HANDLER : PEND;
      HANDLER:
        if (is_eret) state_d = RUN;
        else if (illegal_op) dfault_d = 1'b1;
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      estatus_q <= ESTATUS_W'(CAUSE_NONE);
      iack_q <= '0;
      dfault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      estatus_q <= estatus_d;
      iack_q <= iack_d;
      dfault_q <= dfault_d;
    end
  end
  assign exc = state_q == PEND;
  assign in_handler = state_q == HANDLER;
  assign eret = in_handler && is_eret;
  assign estatus = estatus_q;
  assign ext_iack = iack_q;
  assign double_fault = dfault_q;
endmodule
